uart_cmd_bridge: RTL and testbench
==================================

Name: uart_cmd_bridge

Overview:
Parametrised UART-to-memory command bridge. It sits between uart_rx/uart_tx and the hyper_xface memory controller port. It assembles fixed-length command frames from received bytes, executes each command, and issues single-cycle rd_req/wr_req to the controller after waiting on busy. It then serialises a status byte plus a DATA_BYTES-wide response, MSB first, through the transmitter handshake.

Parameters:
DATA_BYTES, 4, payload bytes per frame and per response; data/addr width W = 8*DATA_BYTES
TIMEOUT_CYCLES, 24000, idle clocks after which a partial frame is discarded (minimum 2)
CONST_VALUE, 259, value returned by CONST command (truncated to W)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rcv  in  1  one-cycle strobe from uart_rx, rx_data valid
rx_data  in  8  received byte
tx_ready  in  1  uart_tx idle
tx_start  out  1  one-cycle start strobe to uart_tx
tx_data  out  8  byte to transmit, held stable from tx_start until tx_ready falls
addr  out  W  memory address
wr_d  out  W  memory write data
wr_req  out  1  one-cycle write request
rd_req  out  1  one-cycle read request
busy  in  1  controller busy; requests only issued when low
rd_rdy  in  1  one-cycle strobe, rd_d valid
rd_d  in  W  read data
drop  out  1  one-cycle pulse: byte discarded because the bridge was not in RX
timeout  out  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset (rstn low, async): every output is 0. Byte count, TX counter, timeout counter, count register and read-data latch are 0. FSM is in RX.
- Frame: cmd byte, then DATA_BYTES payload bytes, MSB first. Frame length L = 1+DATA_BYTES (+1 with the optional feature).
- States: RX, EXEC, MEM, TX_LOAD, TX_WAIT_LO, TX_WAIT_HI.
- RX: on rcv, shift in rx_data and increment the byte count. When byte L is received, clear the byte count and go to EXEC the next cycle.
- RX timeout: the timeout counter resets on each rcv. If the byte count is nonzero and the counter reaches TIMEOUT_CYCLES, clear the byte count and pulse timeout. This has no effect when the byte count is 0.
- rcv in any state other than RX: byte ignored, drop pulses. The frame in progress is unaffected.
- EXEC (one cycle), by command. Each sets status S and response R:
  - 0x01 ADDR: addr <= payload; S=0x01, R=payload.
  - 0x02 LOAD: wr_d <= payload; S=0x02, R=payload.
  - 0x03 WRITE: go to MEM (write); S=0x03, R=addr.
  - 0x04 READ: S=0x04, R=read-data latch.
  - 0x05 READ_REQ: go to MEM (read); S=0x05, R=addr.
  - 0x06 COUNT: R=count, count <= count+1, wrapping at 2^W; S=0x06.
  - 0x07 CONST: S=0x07, R=CONST_VALUE.
  - Other codes: S=0xFF, R=0, no side effects.
- MEM: wait while busy is high. In the first cycle busy is low, pulse wr_req or rd_req for exactly one cycle, then go to TX_LOAD. The response does not wait for rd_rdy.
- rd_rdy in any state latches rd_d into the read-data latch on the same clock edge. No posedge-rd_rdy clocking is permitted.
- TX sequence: send DATA_BYTES+1 bytes: S, then R MSB first.
  - TX_LOAD: when tx_ready is high, drive tx_data and pulse tx_start, then go to TX_WAIT_LO.
  - TX_WAIT_LO: wait for tx_ready low. uart_tx takes up to 2 cycles to drop ready; tx_start is not reasserted.
  - TX_WAIT_HI: wait for tx_ready high. Then decrement the TX counter: go to TX_LOAD if bytes remain, else RX.
- Exactly DATA_BYTES+1 tx_start pulses per frame.
- Reset mid-operation: immediate return to the reset state. Any pending request is not issued. A partial response is abandoned.

Optional Feature:
CMD_CHECKSUM_EN:
- Defined: frame carries a trailing checksum byte equal to the XOR of all preceding frame bytes. On mismatch, EXEC does no side effects and sends S=0xFE, R=0.
- Undefined: no checksum byte; L=1+DATA_BYTES.

Test Plan:
- DATA_BYTES=4, send 01 00 00 00 2A -> addr=0x0000002A; tx bytes 01 00 00 00 2A; exactly 5 tx_start pulses.
- Send 02 DE AD BE EF, then 03 00 00 00 00 with busy held high 10 cycles -> wr_d=0xDEADBEEF; wr_req is a single pulse on the first cycle busy is low; response 03 00 00 00 2A.
- Send 05 xx xx xx xx, drive rd_rdy with rd_d=0x12345678, then send 04 xx xx xx xx -> rd_req is one pulse; second response is 04 12 34 56 78.
- Send 06 frame three times -> data 0, 1, 2; then send 07 frame -> 07 00 00 01 03; send 09 frame -> FF 00 00 00 00.
- Send 3 bytes, idle TIMEOUT_CYCLES -> timeout pulse; next full ADDR frame is decoded correctly. Send bytes during TX -> drop pulse per byte; response unchanged.
- CMD_CHECKSUM_EN defined, send 07 00 00 00 00 07 -> 07 00 00 01 03; send a bad checksum -> FE 00 00 00 00. Assert rstn low mid-MEM -> no request is issued and all outputs return to 0.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: assembles fixed-length frames, drives a single-request memory port, returns status + response bytes.
// Optional build macro CMD_CHECKSUM_EN appends an XOR checksum byte to every frame.
module uart_cmd_bridge #(
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int CONST_VALUE    = 259
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rcv,
  input  logic [7:0]              rx_data,
  input  logic                    tx_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic [8*DATA_BYTES-1:0] addr,
  output logic [8*DATA_BYTES-1:0] wr_d,
  output logic                    wr_req,
  output logic                    rd_req,
  input  logic                    busy,
  input  logic                    rd_rdy,
  input  logic [8*DATA_BYTES-1:0] rd_d,
  output logic                    drop,
  output logic                    timeout
);

  localparam int W = 8 * DATA_BYTES;
`ifdef CMD_CHECKSUM_EN
  localparam int L = DATA_BYTES + 2;
`else
  localparam int L = DATA_BYTES + 1;
`endif
  localparam int FW  = 8 * L;
  localparam int RW  = 8 * (DATA_BYTES + 1);
  localparam int CW  = $clog2(L + 1);
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TXW = $clog2(DATA_BYTES + 2);

  typedef enum logic [2:0] {
    S_RX, S_EXEC, S_MEM, S_TX_LOAD, S_TX_WAIT_LO, S_TX_WAIT_HI
  } state_t;

  state_t          state, state_nx;
  logic [FW-1:0]   frame_q;
  logic [RW-1:0]   resp_q;
  logic [CW-1:0]   byte_cnt;
  logic [TMW-1:0]  tmo_cnt;
  logic [TXW-1:0]  tx_cnt;
  logic [W-1:0]    count_q;
  logic [W-1:0]    rd_latch;
  logic            mem_wr;

  logic [7:0]      cmd;
  logic [W-1:0]    payload;
  logic            ck_ok;
  logic            byte_last;
  logic [7:0]      exec_s;
  logic [W-1:0]    exec_r;
  logic            exec_mem;
  logic            exec_wr;

  assign cmd       = frame_q[FW-1 -: 8];
  assign payload   = frame_q[FW-9 -: W];
  assign byte_last = (byte_cnt == CW'(L - 1));

`ifdef CMD_CHECKSUM_EN
  // XOR over the whole frame including its checksum is zero exactly when the checksum matches.
  logic [7:0] ck_x;
  always_comb begin
    ck_x = 8'h00;
    for (int i = 0; i < L; i++) ck_x = ck_x ^ frame_q[8*i +: 8];
  end
  assign ck_ok = (ck_x == 8'h00);
`else
  assign ck_ok = 1'b1;
`endif

  always_comb begin
    exec_s   = 8'hFF;
    exec_r   = '0;
    exec_mem = 1'b0;
    exec_wr  = 1'b0;
    if (!ck_ok) begin
      exec_s = 8'hFE;
    end else begin
      case (cmd)
        8'h01, 8'h02: begin exec_s = cmd; exec_r = payload; end
        8'h03: begin exec_s = cmd; exec_r = addr; exec_mem = 1'b1; exec_wr = 1'b1; end
        8'h04: begin exec_s = cmd; exec_r = rd_latch; end
        8'h05: begin exec_s = cmd; exec_r = addr; exec_mem = 1'b1; end
        8'h06: begin exec_s = cmd; exec_r = count_q; end
        8'h07: begin exec_s = cmd; exec_r = W'(CONST_VALUE); end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_RX;
    else       state <= state_nx;
  end

  // tx handshake: tx_start only while tx_ready is high; tx_data holds until tx_ready falls,
  // and the next byte is offered only after tx_ready has risen again.
  always_comb begin
    state_nx = state;
    case (state)
      S_RX:         if (rcv && byte_last) state_nx = S_EXEC;
      S_EXEC:       state_nx = exec_mem ? S_MEM : S_TX_LOAD;
      S_MEM:        if (!busy) state_nx = S_TX_LOAD;
      S_TX_LOAD:    if (tx_ready) state_nx = S_TX_WAIT_LO;
      S_TX_WAIT_LO: if (!tx_ready) state_nx = S_TX_WAIT_HI;
      S_TX_WAIT_HI: if (tx_ready) state_nx = (tx_cnt == TXW'(1)) ? S_RX : S_TX_LOAD;
      default:      state_nx = S_RX;
    endcase
  end

  always_comb begin
    tx_start = (state == S_TX_LOAD) && tx_ready;
    wr_req   = (state == S_MEM) && !busy && mem_wr;
    rd_req   = (state == S_MEM) && !busy && !mem_wr;
    tx_data  = resp_q[RW-1 -: 8];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_q  <= '0;
      resp_q   <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      tx_cnt   <= '0;
      count_q  <= '0;
      rd_latch <= '0;
      mem_wr   <= 1'b0;
      addr     <= '0;
      wr_d     <= '0;
      drop     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      drop    <= rcv && (state != S_RX);
      timeout <= 1'b0;
      if (rd_rdy) rd_latch <= rd_d;
      case (state)
        S_RX: begin
          if (rcv) begin
            frame_q  <= {frame_q[FW-9:0], rx_data};
            tmo_cnt  <= '0;
            byte_cnt <= byte_last ? '0 : byte_cnt + CW'(1);
          end else if (byte_cnt != '0) begin
            if (tmo_cnt == TMW'(TIMEOUT_CYCLES - 1)) begin
              timeout  <= 1'b1;
              byte_cnt <= '0;
              tmo_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TMW'(1);
            end
          end
        end
        S_EXEC: begin
          resp_q <= {exec_s, exec_r};
          tx_cnt <= TXW'(DATA_BYTES + 1);
          mem_wr <= exec_wr;
          if (ck_ok) begin
            case (cmd)
              8'h01:   addr    <= payload;
              8'h02:   wr_d    <= payload;
              8'h06:   count_q <= count_q + W'(1);
              default: ;
            endcase
          end
        end
        S_TX_WAIT_HI: begin
          if (tx_ready) begin
            resp_q <= resp_q << 8;
            tx_cnt <= tx_cnt - TXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: transaction-level command model, randomized frames, uart_tx stub, per-cycle compare.
// Honours CMD_CHECKSUM_EN the same way the design does.
module tb_uart_cmd_bridge;

  localparam int DB    = 4;
  localparam int W     = 8 * DB;
  localparam int RW    = 8 * (DB + 1);
  localparam int TMO   = 60;
  localparam int CONST = 259;
`ifdef CMD_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
  localparam int L     = DB + 2;
`else
  localparam bit CK_EN = 1'b0;
  localparam int L     = DB + 1;
`endif

  logic         clk, rstn, rcv, tx_ready, tx_start, wr_req, rd_req, busy, rd_rdy, drop, timeout;
  logic [7:0]   rx_data, tx_data;
  logic [W-1:0] addr, wr_d, rd_d;

  logic [7:0]   exp_q[$];
  int           n_cmp, n_bad;
  int           wr_seen, rd_seen, drop_seen, tmo_seen, exp_tmo;
  bit           busy_rand, busy_hold, tx_busy, exp_wr, exp_rd;
  logic [W-1:0] m_addr, m_wrd, m_count, m_latch;

  uart_cmd_bridge #(.DATA_BYTES(DB), .TIMEOUT_CYCLES(TMO), .CONST_VALUE(CONST)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .addr(addr), .wr_d(wr_d),
    .wr_req(wr_req), .rd_req(rd_req), .busy(busy), .rd_rdy(rd_rdy), .rd_d(rd_d),
    .drop(drop), .timeout(timeout)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // command semantics at transaction level
  function automatic logic [RW-1:0] model_exec(input logic [7:0] cmd, input logic [W-1:0] pay, input bit ok);
    logic [7:0]   s;
    logic [W-1:0] r;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    s = cmd;
    r = '0;
    if (!ok) s = 8'hFE;
    else begin
      case (cmd)
        8'h01: begin m_addr = pay; r = pay; end
        8'h02: begin m_wrd = pay; r = pay; end
        8'h03: begin exp_wr = 1'b1; r = m_addr; end
        8'h04: r = m_latch;
        8'h05: begin exp_rd = 1'b1; r = m_addr; end
        8'h06: begin r = m_count; m_count = m_count + 1; end
        8'h07: r = W'(CONST);
        default: s = 8'hFF;
      endcase
    end
    return {s, r};
  endfunction

  // busy driver
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1 busy = busy_rand ? 1'($urandom_range(0, 1)) : busy_hold;
    end
  end

  // uart_tx stub: ready drops 1..2 cycles after start, stays low 1..4 cycles
  initial begin
    tx_ready = 1'b1;
    tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && tx_start) begin
        tx_busy = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_ready = 1'b1;
        tx_busy = 1'b0;
      end
    end
  end

  // scoreboard / per-cycle compare
  initial begin
    logic [7:0] held;
    bit         pend;
    held = 8'h00;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) pend = 1'b0;
      else begin
        if (pend) begin
          if (!tx_ready) pend = 1'b0;
          else chk("tx_data_hold", tx_data, held);
        end
        if (tx_start) begin
          chk("tx_start_while_ready", tx_ready, 1'b1);
          chk("tx_start_once", pend, 1'b0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected_byte: actual %0h required none", tx_data);
          end else chk("tx_byte", tx_data, exp_q.pop_front());
          held = tx_data;
          pend = 1'b1;
        end
        if (wr_req || rd_req) begin
          chk("req_exclusive", wr_req & rd_req, 1'b0);
          chk("req_busy_low", busy, 1'b0);
          chk("req_addr", addr, m_addr);
          if (wr_req) begin
            chk("wr_data", wr_d, m_wrd);
            wr_seen++;
          end
          if (rd_req) rd_seen++;
        end
        if (drop) drop_seen++;
        if (timeout) tmo_seen++;
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rcv = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rcv = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic send_frame_bytes(input logic [7:0] cmd, input logic [W-1:0] pay, input bit bad);
    logic [7:0] ck, b;
    ck = cmd;
    send_byte(cmd);
    for (int i = DB - 1; i >= 0; i--) begin
      gap();
      b = pay[8*i +: 8];
      ck = ck ^ b;
      send_byte(b);
    end
    if (CK_EN) begin
      gap();
      send_byte(bad ? (ck ^ 8'($urandom_range(1, 255))) : ck);
    end
  endtask

  task automatic push_resp(input logic [RW-1:0] resp);
    for (int i = DB; i >= 0; i--) exp_q.push_back(resp[8*i +: 8]);
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || tx_busy) && t < 3000) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_wait: actual %0d bytes outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [W-1:0] pay, input bit bad,
                          input int ndrop, output logic [RW-1:0] resp);
    int wr0, rd0, dr0;
    wr0 = wr_seen;
    rd0 = rd_seen;
    dr0 = drop_seen;
    resp = model_exec(cmd, pay, !(bad && CK_EN));
    push_resp(resp);
    send_frame_bytes(cmd, pay, bad);
    for (int i = 0; i < ndrop; i++) begin
      gap();
      send_byte(8'($urandom_range(0, 255)));
    end
    wait_resp();
    chk("wr_req_count", wr_seen - wr0, exp_wr);
    chk("rd_req_count", rd_seen - rd0, exp_rd);
    chk("drop_count", drop_seen - dr0, ndrop);
    chk("addr_reg", addr, m_addr);
    chk("wr_d_reg", wr_d, m_wrd);
  endtask

  task automatic partial(input int k);
    int n;
    n = 0;
    for (int i = 0; i < k; i++) begin
      if (i > 0) gap();
      send_byte(8'($urandom_range(0, 255)));
    end
    // timeout is registered after TMO idle edges following the last byte's edge
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 3 * TMO);
    chk("timeout_latency", n, TMO + 1);
    exp_tmo++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd(input logic [W-1:0] d);
    @(posedge clk);
    #1 rd_rdy = 1'b1;
    rd_d = d;
    @(posedge clk);
    #1 rd_rdy = 1'b0;
    m_latch = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_start"}, tx_start, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_addr"}, addr, '0);
    chk({tag, "_wr_d"}, wr_d, '0);
    chk({tag, "_wr_req"}, wr_req, 1'b0);
    chk({tag, "_rd_req"}, rd_req, 1'b0);
    chk({tag, "_drop"}, drop, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
  endtask

  initial begin
    logic [RW-1:0] resp;
    logic [7:0]    c;
    int            wr0, t, a;
    rstn = 1'b0; rcv = 1'b0; rx_data = 8'h00; rd_rdy = 1'b0; rd_d = '0;
    busy_rand = 1'b0; busy_hold = 1'b0;
    m_addr = '0; m_wrd = '0; m_count = '0; m_latch = '0;
    n_cmp = 0; n_bad = 0; wr_seen = 0; rd_seen = 0; drop_seen = 0; tmo_seen = 0; exp_tmo = 0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (TMO + 10) @(posedge clk);
    chk("idle_no_timeout", tmo_seen, 0);

    busy_rand = 1'b1;
    do_frame(8'h01, 32'h0000002A, 1'b0, 0, resp);
    chk("pin_addr", resp, 40'h010000002A);
    do_frame(8'h02, 32'hDEADBEEF, 1'b0, 0, resp);
    chk("pin_load", resp, 40'h02DEADBEEF);

    // WRITE with busy held for 10 cycles
    busy_rand = 1'b0;
    busy_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr0 = wr_seen;
    resp = model_exec(8'h03, '0, 1'b1);
    chk("pin_write", resp, 40'h030000002A);
    push_resp(resp);
    send_frame_bytes(8'h03, '0, 1'b0);
    repeat (10) @(posedge clk);
    busy_hold = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 10);
    chk("wr_req_first_low", wr_req, 1'b1);
    wait_resp();
    chk("wr_req_single", wr_seen - wr0, 1);
    busy_rand = 1'b1;

    do_frame(8'h05, $urandom, 1'b0, 0, resp);
    chk("pin_read_req", resp, 40'h050000002A);
    pulse_rd(32'h12345678);
    do_frame(8'h04, $urandom, 1'b0, 0, resp);
    chk("pin_read", resp, 40'h0412345678);
    for (int i = 0; i < 3; i++) begin
      do_frame(8'h06, $urandom, 1'b0, 0, resp);
      chk("pin_count", resp, {8'h06, 32'(i)});
    end
    do_frame(8'h07, $urandom, 1'b0, 0, resp);
    chk("pin_const", resp, 40'h0700000103);
    do_frame(8'h09, $urandom, 1'b0, 0, resp);
    chk("pin_unknown", resp, 40'hFF00000000);

    partial(3);
    do_frame(8'h01, 32'h00001234, 1'b0, 0, resp);
    chk("pin_addr_after_timeout", resp, 40'h0100001234);
    do_frame(8'h07, $urandom, 1'b0, 2, resp);
    chk("pin_const_with_drops", resp, 40'h0700000103);

`ifdef CMD_CHECKSUM_EN
    do_frame(8'h07, 32'h00000000, 1'b0, 0, resp);
    chk("pin_ck_good", resp, 40'h0700000103);
    do_frame(8'h01, 32'h00000055, 1'b1, 0, resp);
    chk("pin_ck_bad", resp, 40'hFE00000000);
`endif

    // reset while waiting in MEM
    busy_rand = 1'b0;
    busy_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame_bytes(($urandom_range(0, 1) == 0) ? 8'h03 : 8'h05, $urandom, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("mem_held_wr", wr_req, 1'b0);
      chk("mem_held_rd", rd_req, 1'b0);
    end
    #1 rstn = 1'b0;
    #1 check_all_zero("reset_mid_mem");
    busy_hold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("in_reset_wr", wr_req, 1'b0);
      chk("in_reset_rd", rd_req, 1'b0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    m_addr = '0; m_wrd = '0; m_count = '0; m_latch = '0;
    exp_q.delete();
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_wr", wr_req, 1'b0);
      chk("post_reset_rd", rd_req, 1'b0);
      chk("post_reset_tx", tx_start, 1'b0);
    end
    check_all_zero("after_reset");
    busy_rand = 1'b1;
    do_frame(8'h06, $urandom, 1'b0, 0, resp);
    chk("pin_count_after_reset", resp, 40'h0600000000);

    // randomized traffic
    for (int it = 0; it < 70; it++) begin
      a = $urandom_range(0, 99);
      if (a < 12) partial($urandom_range(1, L - 1));
      else if (a < 25) pulse_rd($urandom);
      else begin
        c = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 7));
        do_frame(c, $urandom, CK_EN && ($urandom_range(0, 4) == 0), $urandom_range(0, 2), resp);
      end
    end

    chk("timeout_total", tmo_seen, exp_tmo);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
